apb_cmd_bridge: RTL and testbench

Command-to-APB requester that sits directly upstream of the APB slave and drives its PADDR/PWRITE/PENABLE/PSEL/PWDATA pins. It accepts read/write commands on a valid/ready port and buffers them in a small FIFO. It executes each command as one APB transfer (SETUP then ACCESS, honouring PREADY wait states with a timeout) and returns one response per command on a valid/ready response port.

---
 rtl/apb_pkg.sv | 27 ++
 rtl/apb_cmd_bridge_if.sv | 40 ++++
 rtl/apb_cmd_fifo.sv | 61 ++++++
 rtl/apb_cmd_bridge.sv | 140 ++++++++++++++
 tb/tb_apb_cmd_bridge.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types for the command-to-APB bridge: FSM states, default bus widths,
// and the queued command record.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  // The FIFO stores commands at the package widths; the bridge is expected
  // to be instantiated with matching ADDR_W/DATA_W.
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } cmd_t;

  function automatic logic misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/apb_cmd_bridge_if.sv
// Command, response and APB pins of the bridge. The master modport is the
// bridge itself (APB requester); slave is the surrounding environment.
interface apb_cmd_bridge_if import apb_pkg::*; #(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO with a combinational head view so the bridge can
// pop and register the head on the same edge.
module apb_cmd_fifo import apb_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  cmd_t                       push_data,
  input  logic                       pop,
  output cmd_t                       pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  cmd_t             mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem_reg[rd_ptr_reg];
  assign count    = count_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/apb_cmd_bridge.sv
// Queues read/write commands and runs each as one APB transfer with a
// PREADY timeout, returning one response per command.
module apb_cmd_bridge import apb_pkg::*; #(
  parameter int ADDR_W     = APB_ADDR_W,
  parameter int DATA_W     = APB_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input logic              clk,
  input logic              rst_n,
  apb_cmd_bridge_if.master bus
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  cmd_t              push_cmd;
  cmd_t              head_cmd;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  state_t            state_reg;
  logic              psel_reg;
  logic              penable_reg;
  logic              pwrite_reg;
  logic [ADDR_W-1:0] paddr_reg;
  logic [DATA_W-1:0] pwdata_reg;
  logic              rsp_valid_reg;
  logic              rsp_write_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic              rsp_err_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;

  assign push_cmd.write = bus.cmd_write;
  assign push_cmd.addr  = bus.cmd_addr;
  assign push_cmd.wdata = bus.cmd_wdata;

  assign bus.cmd_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign fifo_push     = bus.cmd_valid && !fifo_full;
  assign fifo_pop      = (state_reg == IDLE) && !fifo_empty;

  apb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_write_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      wait_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            paddr_reg     <= head_cmd.addr;
            pwrite_reg    <= head_cmd.write;
            pwdata_reg    <= head_cmd.wdata;
            rsp_write_reg <= head_cmd.write;
            // Misaligned commands complete locally without touching the bus.
            if (misaligned(head_cmd.addr[1:0])) begin
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
              state_reg     <= RESP;
            end else begin
              psel_reg  <= 1'b1;
              state_reg <= SETUP;
            end
          end
        end
        SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= pwrite_reg ? '0 : bus.PRDATA;
            state_reg     <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
            if (wait_cnt_reg == WAIT_W'(TIMEOUT - 1)) begin
              psel_reg      <= 1'b0;
              penable_reg   <= 1'b0;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
              rsp_rdata_reg <= '0;
              state_reg     <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            wait_cnt_reg  <= '0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.PSEL      = psel_reg;
  assign bus.PENABLE   = penable_reg;
  assign bus.PWRITE    = pwrite_reg;
  assign bus.PADDR     = paddr_reg;
  assign bus.PWDATA    = pwdata_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_write = rsp_write_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb_cmd_bridge.sv
// Directed test of apb_cmd_bridge against a small APB completer model with
// programmable wait states and a stuck-low PREADY mode.
module tb_apb_cmd_bridge;

  localparam int TIMEOUT = 16;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_cmd_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_cmd_bridge #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // APB completer: PREADY rises after wait_n low ACCESS cycles unless stuck.
  int          wait_n = 0;
  logic        stuck = 1'b0;
  int          acc_cnt = 0;
  logic [31:0] mem [16];
  int          psel_cycles = 0;
  int          pen_cycles = 0;
  logic [31:0] last_paddr = '0;
  logic [31:0] last_pwdata = '0;
  logic        last_pwrite = 1'b0;

  assign bus.PREADY = !stuck && (acc_cnt >= wait_n);
  assign bus.PRDATA = (bus.PADDR == 32'h4) ? 32'hCAFE_0004 : mem[bus.PADDR[5:2]];

  always @(posedge clk) begin
    if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
    else                                        acc_cnt <= 0;
    if (bus.PSEL) psel_cycles <= psel_cycles + 1;
    if (bus.PSEL && bus.PENABLE) pen_cycles <= pen_cycles + 1;
    if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
      last_paddr  <= bus.PADDR;
      last_pwdata <= bus.PWDATA;
      last_pwrite <= bus.PWRITE;
      if (bus.PWRITE) mem[bus.PADDR[5:2]] <= bus.PWDATA;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_cmd(input logic w, input logic [31:0] addr, input logic [31:0] data);
    int g;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    g = 0;
    while (!bus.cmd_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!bus.cmd_ready) begin
      check_val("cmd_accept_wait", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    $display("cmd write=%0d addr=0x%08h wdata=0x%08h", w, addr, data);
  endtask

  // Counts edges from the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid) check_val("rsp_wait_timeout", 64'(bus.rsp_valid), 64'd1);
  endtask

  task automatic take_rsp(input string tag, input logic w, input logic [31:0] rdata, input logic err);
    int lat;
    wait_rsp(lat);
    check_val({tag, "_write"}, 64'(bus.rsp_write), 64'(w));
    check_val({tag, "_rdata"}, 64'(bus.rsp_rdata), 64'(rdata));
    check_val({tag, "_err"},   64'(bus.rsp_err),   64'(err));
    $display("rsp %s write=%0d rdata=0x%08h err=%0d", tag, bus.rsp_write, bus.rsp_rdata, bus.rsp_err);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int snap;
    logic rdy4;
    logic rdy5;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_val("rst_psel",      64'(bus.PSEL),      64'd0);
    check_val("rst_penable",   64'(bus.PENABLE),   64'd0);
    check_val("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_val("rst_paddr",     64'(bus.PADDR),     64'd0);
    check_val("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Write 0x0 = 6 then read it back, zero wait states.
    snap = psel_cycles;
    send_cmd(1'b1, 32'h0, 32'h6);
    wait_rsp(lat);
    check_val("wr_latency",    64'(lat), 64'd3);
    check_val("wr_psel_cyc",   64'(psel_cycles - snap), 64'd2);
    check_val("wr_paddr",      64'(last_paddr),  64'h0);
    check_val("wr_pwdata",     64'(last_pwdata), 64'h6);
    check_val("wr_pwrite",     64'(last_pwrite), 64'd1);
    take_rsp("wr0", 1'b1, 32'h0, 1'b0);
    check_val("wr_rsp_drop",   64'(bus.rsp_valid), 64'd0);

    send_cmd(1'b0, 32'h0, 32'h0);
    wait_rsp(lat);
    check_val("rd_latency", 64'(lat), 64'd3);
    take_rsp("rd0", 1'b0, 32'h6, 1'b0);

    // Three PREADY-low ACCESS cycles.
    wait_n = 3;
    snap = pen_cycles;
    send_cmd(1'b0, 32'h4, 32'h0);
    wait_rsp(lat);
    check_val("ws_latency",    64'(lat), 64'd6);
    check_val("ws_access_cyc", 64'(pen_cycles - snap), 64'd4);
    take_rsp("rd4", 1'b0, 32'hCAFE_0004, 1'b0);
    wait_n = 0;

    // PREADY stuck low: abort after TIMEOUT ACCESS cycles.
    stuck = 1'b1;
    snap = pen_cycles;
    send_cmd(1'b0, 32'h8, 32'h0);
    wait_rsp(lat);
    check_val("to_latency",    64'(lat), 64'(2 + TIMEOUT));
    check_val("to_access_cyc", 64'(pen_cycles - snap), 64'(TIMEOUT));
    check_val("to_psel_resp",  64'(bus.PSEL), 64'd0);
    check_val("to_pen_resp",   64'(bus.PENABLE), 64'd0);
    take_rsp("rd8_to", 1'b0, 32'h0, 1'b1);
    stuck = 1'b0;

    // Five back-to-back pushes with responses held off; the first command
    // is popped one edge after its push, so the FIFO fills on the fifth.
    send_cmd(1'b1, 32'h20, 32'hA1);
    send_cmd(1'b0, 32'h20, 32'h0);
    send_cmd(1'b1, 32'h24, 32'hB2);
    send_cmd(1'b0, 32'h24, 32'h0);
    rdy4 = bus.cmd_ready;
    send_cmd(1'b0, 32'h0, 32'h0);
    rdy5 = bus.cmd_ready;
    check_val("bb_ready_4th", 64'(rdy4), 64'd1);
    check_val("bb_ready_5th", 64'(rdy5), 64'd0);
    take_rsp("bb0", 1'b1, 32'h0,  1'b0);
    take_rsp("bb1", 1'b0, 32'hA1, 1'b0);
    take_rsp("bb2", 1'b1, 32'h0,  1'b0);
    take_rsp("bb3", 1'b0, 32'hB2, 1'b0);
    take_rsp("bb4", 1'b0, 32'h6,  1'b0);
    check_val("bb_ready_end", 64'(bus.cmd_ready), 64'd1);

    // Misaligned address: no bus activity, error one edge after accept.
    snap = psel_cycles;
    send_cmd(1'b1, 32'h6, 32'h55);
    wait_rsp(lat);
    check_val("mis_latency",  64'(lat), 64'd1);
    check_val("mis_psel_cyc", 64'(psel_cycles - snap), 64'd0);
    check_val("mis_paddr",    64'(bus.PADDR), 64'h6);
    take_rsp("mis6", 1'b1, 32'h0, 1'b1);

    // Reset while in ACCESS with commands queued behind.
    stuck = 1'b1;
    send_cmd(1'b0, 32'h8, 32'h0);
    send_cmd(1'b1, 32'h30, 32'h1);
    send_cmd(1'b1, 32'h34, 32'h2);
    lat = 0;
    while (!bus.PENABLE && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_val("rr_in_access", 64'(bus.PENABLE), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("rr_psel",      64'(bus.PSEL),      64'd0);
    check_val("rr_penable",   64'(bus.PENABLE),   64'd0);
    check_val("rr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stuck = 1'b0;
    check_val("rr_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    snap = psel_cycles;
    repeat (5) @(negedge clk);
    check_val("rr_no_psel",   64'(psel_cycles - snap), 64'd0);
    check_val("rr_no_rsp",    64'(bus.rsp_valid), 64'd0);
    check_val("rr_ready_end", 64'(bus.cmd_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
